// File: rtl/shreg_pkg.sv
// Shared types and helpers for the parametrised load/shift register.
// Used by param_shift_reg and shreg_step.
package shreg_pkg;

   typedef enum logic [2:0] {
      MODE_LSL = 3'b000,
      MODE_LSR = 3'b001,
      MODE_ASR = 3'b010,
      MODE_ROL = 3'b011,
      MODE_ROR = 3'b100
   } shift_mode_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Shifting further than the register width is indistinguishable from shifting by the width.
   function automatic int clamp_amt(input int amt, input int width);
      return (amt > width) ? width : amt;
   endfunction

   function automatic logic mode_is_valid(input logic [2:0] m);
      return (m <= MODE_ROR);
   endfunction

   function automatic logic mode_is_right(input shift_mode_t m);
      return (m == MODE_LSR) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/shreg_step.sv
// Single-bit combinational shift/rotate step for the shift register.
// Reserved mode codes pass the value through unchanged.
module shreg_step
   import shreg_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_value,
   input  shift_mode_t      i_mode,
   input  logic             i_fill_lsb,
   input  logic             i_fill_msb,
   output logic [WIDTH-1:0] o_next,
   output logic             o_out
);

   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
      o_next = i_value;
      o_out  = 1'b0;
      case (i_mode)
         MODE_LSL: begin
            o_next = {i_value[WIDTH-2:0], i_fill_lsb};
            o_out  = i_value[WIDTH-1];
         end
         MODE_LSR: begin
            o_next = {i_fill_msb, i_value[WIDTH-1:1]};
            o_out  = i_value[0];
         end
         MODE_ASR: begin
            o_next = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
            o_out  = i_value[0];
         end
         MODE_ROL: begin
            o_next = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
            o_out  = i_value[WIDTH-1];
         end
         MODE_ROR: begin
            o_next = {i_value[0], i_value[WIDTH-1:1]};
            o_out  = i_value[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/param_shift_reg.sv
// Parametrised load/shift register: one bit per cycle under a start/busy/done handshake.
// Define SHREG_STICKY_EN to build the sticky (OR of right-shifted-out bits) tracker.
module param_shift_reg
   import shreg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in_lsb,
   input  logic             ser_in_msb,
   output logic [WIDTH-1:0] par_out,
   output logic             MSB_out,
   output logic             LSB_out,
   output logic             so_bit,
   output logic             busy,
   output logic             done,
   output logic             sticky
);

   state_t           r_state;
   shift_mode_t      r_mode;
   logic [AMT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_data;
   logic             r_so;
   logic             r_busy;
   logic             r_done;

   logic [AMT_W-1:0] w_amt;
   logic             w_idle;
   logic             w_load;
   logic             w_accept;
   logic             w_nop;
   logic             w_step_en;
   shift_mode_t      w_step_mode;
   logic [WIDTH-1:0] w_next;
   logic             w_out;

   assign w_amt       = AMT_W'(clamp_amt(int'(amt), WIDTH));
   assign w_idle      = (r_state == IDLE);
   assign w_load      = w_idle & ld;
   assign w_accept    = w_idle & ~ld & start;
   assign w_nop       = w_accept & ((w_amt == '0) | ~mode_is_valid(mode));
   assign w_step_en   = (w_accept & ~w_nop) | ~w_idle;
   // The first step uses the live mode; later steps use the copy latched at start.
   assign w_step_mode = w_idle ? shift_mode_t'(mode) : r_mode;

   shreg_step #(.WIDTH(WIDTH)) u_step (
      .i_value   (r_data),
      .i_mode    (w_step_mode),
      .i_fill_lsb(ser_in_lsb),
      .i_fill_msb(ser_in_msb),
      .o_next    (w_next),
      .o_out     (w_out)
   );

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
      if (rst) begin
         r_state <= IDLE;
         r_mode  <= MODE_LSL;
         r_cnt   <= '0;
         r_data  <= '0;
         r_so    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load) r_data <= par_in;
         if (w_step_en) begin
            r_data <= w_next;
            r_so   <= w_out;
         end
         if (w_nop) r_done <= 1'b1;
         if (w_accept && !w_nop) begin
            r_mode <= w_step_mode;
            if (w_amt == AMT_W'(1)) begin
               r_done <= 1'b1;
            end else begin
               r_cnt   <= w_amt - AMT_W'(1);
               r_state <= SHIFT;
               r_busy  <= 1'b1;
            end
         end
         if (!w_idle) begin
            r_cnt <= r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
         end
      end
   end

`ifdef SHREG_STICKY_EN
   logic r_sticky;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky <= 1'b0;
      end else if (w_load || w_accept) begin
         r_sticky <= w_step_en & mode_is_right(w_step_mode) & w_out;
      end else if (w_step_en) begin
         r_sticky <= r_sticky | (mode_is_right(w_step_mode) & w_out);
      end
   end

   assign sticky = r_sticky;
`else
   assign sticky = 1'b0;
`endif

   assign par_out = r_data;
   assign MSB_out = r_data[WIDTH-1];
   assign LSB_out = r_data[0];
   assign so_bit  = r_so;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised successor to the team's fixed 16-bit load/shift register.
- Adds configurable width, five shift modes and multi-bit shifts. A multi-bit shift runs one bit per cycle under a start/busy/done handshake.
- Sits in datapaths as the operand shifter for serial multiply/divide and normalisation steps, driven by a controller FSM.

Parameters:
- WIDTH, 16, register width in bits (>= 2).
- AMT_W, $clog2(WIDTH+1), width of the shift-amount input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ld  input  1  parallel load request.
- start  input  1  begin shift of amt positions.
- mode  input  3  shift mode (see Behaviour).
- amt  input  AMT_W  shift count; values above WIDTH are clamped to WIDTH.
- par_in  input  WIDTH  parallel load data.
- ser_in_lsb  input  1  fill bit entering bit 0 on LSL.
- ser_in_msb  input  1  fill bit entering bit WIDTH-1 on LSR.
- par_out  output  WIDTH  register contents.
- MSB_out  output  1  par_out[WIDTH-1], combinational.
- LSB_out  output  1  par_out[0], combinational.
- so_bit  output  1  last bit shifted out, registered.
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle pulse: operation complete.
- sticky  output  1  OR of bits lost on right shifts (optional feature).

Behaviour:
- Reset (synchronous, active-high, clk domain): par_out=0, so_bit=0, busy=0, done=0, sticky=0, state=IDLE. Reset mid-shift aborts the shift; no done pulse is produced.
- Mode codes:
  - 000 LSL: fill from ser_in_lsb.
  - 001 LSR: fill from ser_in_msb.
  - 010 ASR: MSB replicated.
  - 011 ROL.
  - 100 ROR.
  - 101-111 reserved.
- States: IDLE, SHIFT.
- IDLE:
  - ld=1: par_out<=par_in at that edge. ld has priority over start; start in the same cycle is ignored, no done.
  - start=1, ld=0, amt=0 or reserved mode: no data change; done=1 for the next cycle.
  - start=1, ld=0, amt=N>=1: mode is latched and the first shift step happens at this edge, k.
    - N=1: stay IDLE; done=1 next cycle.
    - N>1: counter<=N-1, go SHIFT, busy=1.
- SHIFT:
  - One step per edge; counter decrements each step.
  - At the edge where counter=1, perform the final step, go IDLE, busy<=0, done<=1.
  - Net effect: steps at edges k..k+N-1; done high in the cycle after edge k+N-1; busy high from edge k through edge k+N-1, deasserting with the final step.
  - ld and start are ignored while busy.
  - mode, ser_in_lsb and ser_in_msb:
    - mode is latched at start.
    - ser_in_lsb and ser_in_msb are sampled live at every step edge.
- so_bit updates at every step:
  - Left modes: old bit WIDTH-1.
  - Right modes: old bit 0.
  - Unchanged by ld.
- Rotates by WIDTH restore the original value. LSL/LSR by WIDTH yields all fill bits. ASR by WIDTH yields all sign bits.
- done never coincides with busy=1 for a new operation: start can be reissued in the done cycle.

Optional Feature:
- SHREG_STICKY_EN defined:
  - sticky is cleared on ld and on accepted start.
  - sticky then ORs every bit shifted out by LSR or ASR steps; it is valid when done=1.
  - Used for rounding in normalisation.
- Undefined: sticky is tied to 0 and no sticky logic is built; the port is kept so the interface is identical.

Decomposition:
- Package shreg_pkg holds:
  - shift_mode_t enum: MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL, MODE_ROR.
  - state_t enum: IDLE, SHIFT.
  - Function clamp_amt.
- Sub-module shreg_step: purely combinational single-bit step. Inputs: value, mode, fill bits. Outputs: next value, out bit. Instantiated once in param_shift_reg.

Test Plan:
- WIDTH=16, ld par_in=16'hA5C3 -> par_out=16'hA5C3 next cycle; MSB_out=1, LSB_out=1; no done.
- Mode LSR, amt=4, ser_in_msb=0 -> busy for 3 cycles, done one cycle later, par_out=16'h0A5C, so_bit=0. With SHREG_STICKY_EN, sticky=1 (bits 3..0 were 0011).
- Mode ASR, amt=16 on 16'h8001 -> par_out=16'hFFFF after 16 steps, done pulse exactly once.
- Mode ROL, amt=1 on 16'h8000 -> par_out=16'h0001 next cycle, done next cycle, busy never high. Start with amt=0 or mode=3'b110 -> done only, data unchanged.
- Assert rst during SHIFT step 2 of an amt=8 LSL -> par_out=0, busy=0, no done. ld and start pulsed while busy -> ignored.
- ld and start together in IDLE -> load wins, no done. Start reissued in the done cycle -> accepted.
